// File: rtl/uart_rx_ascii.sv
// uart_rx_ascii: 8N1 UART receiver delivering each good byte with a one-cycle strobe and flagging bad stop bits.
module uart_rx_ascii #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_data,
  output logic       data_came,
  output logic       frame_error
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic rx_s;
  assign rx_s = sync[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx};
  // Leaving STOP at mid-bit gives half a bit of margin to catch a back-to-back start bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= WAIT_HIGH;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      ascii_data  <= '0;
      data_came   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_came   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START:
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == FULL) begin
            cnt <= '0;
            if (rx_s) begin
              ascii_data <= shreg;
              data_came  <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else cnt <= cnt + 1'b1;
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= WAIT_HIGH;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_ascii.sv
// tb_uart_rx_ascii: vector table, directed corner sequences and random frames against a frame-level model.
module tb_uart_rx_ascii;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] ascii_data;
  logic data_came, frame_error;
  int pass_cnt = 0, total = 0;
  int cyc = 0, dc_cnt = 0, fe_cnt = 0;
  int dc_cycs[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_data;

  uart_rx_ascii #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .ascii_data(ascii_data), .data_came(data_came), .frame_error(frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (data_came || frame_error) chk("pulse_exclusive", int'(data_came & frame_error), 0);
    if (data_came) begin
      dc_cnt++;
      dc_cycs.push_back(cyc);
      rx_q.push_back(ascii_data);
    end
    if (frame_error) fe_cnt++;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
  endtask

  // Frame-level model: a good stop bit delivers the byte, a bad one only raises the error.
  task automatic frame_check(input string name, input logic [7:0] b, input logic stop, input int gap);
    int dc0, fe0;
    dc0 = dc_cnt;
    fe0 = fe_cnt;
    send_frame(b, stop);
    if (stop) exp_data = b;
    if (gap > 0) idle(gap);
    chk({name, "_dc"}, dc_cnt - dc0, int'(stop));
    chk({name, "_fe"}, fe_cnt - fe0, int'(!stop));
    chk({name, "_data"}, int'(ascii_data), int'(exp_data));
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int c0, dc0, fe0, n;
    vecs[0] = '{8'h00, 1'b1};
    vecs[1] = '{8'hFF, 1'b1};
    vecs[2] = '{8'hA5, 1'b1};
    vecs[3] = '{8'h5A, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1};
    vecs[6] = '{8'h7E, 1'b0};
    vecs[7] = '{8'h39, 1'b1};
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_data", int'(ascii_data), 0);
    chk("reset_dc", int'(data_came), 0);
    chk("reset_fe", int'(frame_error), 0);
    rst = 1'b0;
    idle(20);

    c0 = cyc;
    frame_check("first_31", 8'h31, 1'b1, 20);
    n = dc_cycs.size();
    chk("latency_31", int'((n > 0) && (dc_cycs[n-1] - c0 >= 154) && (dc_cycs[n-1] - c0 <= 156)), 1);

    rx_q.delete();
    dc_cycs.delete();
    send_frame(8'h31, 1'b1);
    send_frame(8'h63, 1'b1);
    exp_data = 8'h63;
    idle(20);
    chk("b2b_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_first", int'(rx_q[0]), 'h31);
      chk("b2b_second", int'(rx_q[1]), 'h63);
      chk("b2b_spacing", dc_cycs[1] - dc_cycs[0], 160);
    end

    dc0 = dc_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    chk("glitch_dc", dc_cnt - dc0, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);
    frame_check("after_glitch_2b", 8'h2B, 1'b1, 20);

    frame_check("pre_err_31", 8'h31, 1'b1, 20);
    dc0 = dc_cnt;
    fe0 = fe_cnt;
    send_frame(8'h2B, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("ferr_hold_data", int'(ascii_data), 'h31);
    idle(20);
    chk("ferr_pulse", fe_cnt - fe0, 1);
    chk("ferr_no_dc", dc_cnt - dc0, 0);
    chk("ferr_keep_data", int'(ascii_data), 'h31);
    frame_check("after_err_35", 8'h35, 1'b1, 20);

    dc0 = dc_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h63 >> i);
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data", int'(ascii_data), 0);
    chk("midrst_dc", int'(data_came), 0);
    chk("midrst_fe", int'(frame_error), 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("midrst_no_pulse", (dc_cnt - dc0) + (fe_cnt - fe0), 0);
    exp_data = 8'h00;
    frame_check("after_rst_37", 8'h37, 1'b1, 20);

    foreach (vecs[i]) frame_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop, 20);

    for (int i = 0; i < 25; i++) begin
      logic [7:0] b;
      logic s;
      b = 8'($urandom);
      s = ($urandom_range(4) != 0);
      frame_check($sformatf("rnd%0d", i), b, s, s ? int'($urandom_range(3)) : 4 + int'($urandom_range(8)));
    end
    idle(40);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
